// File: rtl/download_packer.sv
// Packs 16-bit ioctl download words into 64-bit byte-masked beats for the ROM
// region in DDR, queued behind a small FIFO with upstream wait backpressure.
module download_packer #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          ADDR_WIDTH  = 27,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_in_cs,
  input  logic                  io_in_wr,
  input  logic [7:0]            io_in_index,
  input  logic [ADDR_WIDTH-1:0] io_in_addr,
  input  logic [15:0]           io_in_dout,
  output logic                  io_in_waitReq,
  output logic                  io_out_wr,
  input  logic                  io_out_waitReq,
  output logic [31:0]           io_out_addr,
  output logic [63:0]           io_out_data,
  output logic [7:0]            io_out_mask,
  output logic [7:0]            io_out_index,
  output logic                  io_done
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, FILL, FLUSH, DRAIN} state_t;

  state_t                state;
  logic                  cs_q;
  logic [63:0]           p_data;
  logic [7:0]            p_mask;
  logic [ADDR_WIDTH-1:0] p_base;

  logic [63:0]           q_data [QUEUE_DEPTH];
  logic [7:0]            q_mask [QUEUE_DEPTH];
  logic [31:0]           q_addr [QUEUE_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;

  logic                  cs_rise, accept, pop, push, full;
  logic [1:0]            lane;
  logic [ADDR_WIDTH-1:0] wbase;
  logic [63:0]           lane_data, merged_data, push_data, np_data;
  logic [7:0]            lane_mask, merged_mask, push_mask, np_mask;
  logic [ADDR_WIDTH-1:0] push_base, np_base;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = io_in_addr[0];
  assign cs_rise   = io_in_cs && !cs_q;
  assign io_out_wr = (count != '0);
  assign pop       = io_out_wr && !io_out_waitReq;
  assign full      = (count == CW'(QUEUE_DEPTH));
  assign accept    = (state == FILL) && io_in_wr && !io_in_waitReq;

  assign io_out_data = q_data[rd_ptr];
  assign io_out_mask = q_mask[rd_ptr];
  assign io_out_addr = q_addr[rd_ptr];

  // A word landing in a different 8-byte word evicts the current partial first.
  always_comb begin
    lane        = io_in_addr[2:1];
    wbase       = {io_in_addr[ADDR_WIDTH-1:3], 3'b000};
    lane_data   = {48'h0, io_in_dout} << {lane, 4'b0000};
    lane_mask   = 8'b0000_0011 << {lane, 1'b0};
    merged_data = (p_data & ~(64'hFFFF << {lane, 4'b0000})) | lane_data;
    merged_mask = p_mask | lane_mask;
    push        = 1'b0;
    push_data   = p_data;
    push_mask   = p_mask;
    push_base   = p_base;
    np_data     = p_data;
    np_mask     = p_mask;
    np_base     = p_base;
    if (state == IDLE && cs_rise) begin
      np_data = '0;
      np_mask = '0;
      np_base = '0;
    end else if (accept) begin
      if (p_mask != 8'h00 && wbase != p_base) begin
        push    = 1'b1;
        np_data = lane_data;
        np_mask = lane_mask;
        np_base = wbase;
      end else if (merged_mask == 8'hFF) begin
        push      = 1'b1;
        push_data = merged_data;
        push_mask = merged_mask;
        push_base = wbase;
        np_data   = '0;
        np_mask   = '0;
        np_base   = '0;
      end else begin
        np_data = merged_data;
        np_mask = merged_mask;
        np_base = wbase;
      end
    end else if (state == FLUSH && p_mask != 8'h00 && (!full || pop)) begin
      push    = 1'b1;
      np_data = '0;
      np_mask = '0;
      np_base = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_data[i] <= '0;
        q_mask[i] <= '0;
        q_addr[i] <= '0;
      end
    end else begin
      if (push) begin
        q_data[wr_ptr] <= push_data;
        q_mask[wr_ptr] <= push_mask;
        q_addr[wr_ptr] <= BASE_ADDR + 32'(push_base);
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Wait lags the queue by a cycle; the one-entry headroom absorbs that lag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cs_q          <= 1'b0;
      p_data        <= '0;
      p_mask        <= '0;
      p_base        <= '0;
      io_out_index  <= '0;
      io_done       <= 1'b0;
      io_in_waitReq <= 1'b0;
    end else begin
      cs_q          <= io_in_cs;
      p_data        <= np_data;
      p_mask        <= np_mask;
      p_base        <= np_base;
      io_done       <= 1'b0;
      io_in_waitReq <= (count >= CW'(QUEUE_DEPTH - 1)) || state == FLUSH || state == DRAIN;
      case (state)
        IDLE: begin
          if (cs_rise) begin
            io_out_index <= io_in_index;
            state        <= FILL;
          end
        end
        FILL: begin
          if (!io_in_cs) state <= FLUSH;
        end
        FLUSH: begin
          if (p_mask == 8'h00 || push) state <= DRAIN;
        end
        DRAIN: begin
          if (count == '0 || (count == CW'(1) && pop)) begin
            io_done <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
